// File: rtl/uart_ram_loader_pkg.sv
// Shared types and sizing for the UART-to-RAM loader.
package uart_ram_loader_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    START = 3'd1,
    DATA  = 3'd2,
    STOP  = 3'd3,
    WRITE = 3'd4
  } uart_rx_state_t;

  localparam int ADDR_W = 8;
  localparam int DATA_W = 8;

  function automatic int clks_per_bit(input int clk_hz, input int baud);
    return clk_hz / baud;
  endfunction

endpackage

// File: rtl/uart_ram_loader_rx.sv
// 8N1 bit-level receiver: synchronizer, framing FSM, one-cycle valid/frame_err pulses.
module uart_rx
  import uart_ram_loader_pkg::*;
#(
  parameter int CLKS_PER_BIT = 434
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       en,
  input  logic       rx,
  output logic [7:0] data,
  output logic       valid,
  output logic       frame_err,
  output logic       busy
);

  localparam int CW = $clog2(CLKS_PER_BIT + 1);
  localparam logic [CW-1:0] FULL = CW'(CLKS_PER_BIT - 1);
  localparam logic [CW-1:0] HALF = CW'(CLKS_PER_BIT / 2 - 1);

  uart_rx_state_t state;
  logic          sync1;
  logic          rx_s;
  logic          armed;
  logic [CW-1:0] baud_cnt;
  logic [2:0]    bit_cnt;
  logic [7:0]    shift;

  assign busy = (state != IDLE);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync1     <= 1'b1;
      rx_s      <= 1'b1;
      state     <= IDLE;
      armed     <= 1'b0;
      baud_cnt  <= '0;
      bit_cnt   <= '0;
      shift     <= '0;
      data      <= '0;
      valid     <= 1'b0;
      frame_err <= 1'b0;
    end else begin
      sync1     <= rx;
      rx_s      <= sync1;
      valid     <= 1'b0;
      frame_err <= 1'b0;
      // Disable abandons any frame in flight; the line must idle high again before re-arming.
      if (state != IDLE && !en) begin
        state    <= IDLE;
        armed    <= 1'b0;
        baud_cnt <= '0;
        bit_cnt  <= '0;
      end else begin
        case (state)
          IDLE: begin
            if (rx_s) armed <= 1'b1;
            if (en && !rx_s && armed) begin
              state    <= START;
              baud_cnt <= '0;
              bit_cnt  <= '0;
            end
          end
          START: begin
            if (baud_cnt == HALF) begin
              baud_cnt <= '0;
              if (rx_s) begin
                state <= IDLE;
                armed <= 1'b0;
              end else begin
                state <= DATA;
              end
            end else begin
              baud_cnt <= baud_cnt + CW'(1);
            end
          end
          DATA: begin
            if (baud_cnt == FULL) begin
              baud_cnt <= '0;
              shift    <= {rx_s, shift[7:1]};
              if (bit_cnt == 3'd7) begin
                bit_cnt <= '0;
                state   <= STOP;
              end else begin
                bit_cnt <= bit_cnt + 3'd1;
              end
            end else begin
              baud_cnt <= baud_cnt + CW'(1);
            end
          end
          STOP: begin
            if (baud_cnt == FULL) begin
              baud_cnt <= '0;
              if (rx_s) begin
                state <= WRITE;
                data  <= shift;
                valid <= 1'b1;
              end else begin
                state     <= IDLE;
                armed     <= 1'b0;
                frame_err <= 1'b1;
              end
            end else begin
              baud_cnt <= baud_cnt + CW'(1);
            end
          end
          WRITE: begin
            state <= IDLE;
            armed <= 1'b0;
          end
          default: begin
            state <= IDLE;
            armed <= 1'b0;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/uart_ram_loader.sv
// Streams received UART bytes into consecutive RAM addresses with sticky status flags.
module uart_ram_loader
  import uart_ram_loader_pkg::*;
#(
  parameter int CLK_HZ = 50_000_000,
  parameter int BAUD   = 115200
) (
  input  logic              clk1_50,
  input  logic              rst_,
  input  logic              en,
  input  logic              clr,
  input  logic              uart_rx,
  output logic              we,
  output logic [ADDR_W-1:0] addr,
  output logic [DATA_W-1:0] din,
  output logic              busy,
  output logic              frame_err,
  output logic              wrapped
);

  localparam int CLKS_PER_BIT = clks_per_bit(CLK_HZ, BAUD);

  logic ferr_pulse;

  uart_rx #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_rx (
    .clk      (clk1_50),
    .rst_n    (rst_),
    .en       (en),
    .rx       (uart_rx),
    .data     (din),
    .valid    (we),
    .frame_err(ferr_pulse),
    .busy     (busy)
  );

  // clr outranks the post-write increment and wrap; the write itself still lands at the old address.
  always_ff @(posedge clk1_50 or negedge rst_) begin
    if (!rst_) begin
      addr      <= '0;
      frame_err <= 1'b0;
      wrapped   <= 1'b0;
    end else if (clr) begin
      addr      <= '0;
      frame_err <= 1'b0;
      wrapped   <= 1'b0;
    end else begin
      if (we) begin
        addr <= addr + ADDR_W'(1);
        if (addr == {ADDR_W{1'b1}}) wrapped <= 1'b1;
      end
      if (ferr_pulse) frame_err <= 1'b1;
    end
  end

endmodule

// File: doc/uart_ram_loader.md
UART_RAM_LOADER -- requirements
Module: uart_ram_loader

Interface
REQ-001 SHALL have parameter CLK_HZ, default 50_000_000, input clock frequency in Hz.
REQ-002 SHALL have parameter BAUD, default 115200, serial bit rate; CLKS_PER_BIT = CLK_HZ/BAUD (integer division, 434 at defaults).
REQ-003 SHALL have ports, clock and reset first:
- clk1_50  input  1  system clock; single clock domain.
- rst_  input  1  asynchronous, active-low reset.
- en  input  1  loader enable; low holds the receiver in IDLE.
- clr  input  1  synchronous clear of write pointer and flags.
- uart_rx  input  1  asynchronous serial line, 8N1, idle high.
- we  output  1  RAM write enable, one-cycle pulse per accepted byte.
- addr  output  8  RAM address; always equals the write pointer.
- din  output  8  RAM write data; last received byte.
- busy  output  1  high whenever FSM is not IDLE.
- frame_err  output  1  sticky flag: stop bit sampled low.
- wrapped  output  1  sticky flag: write pointer wrapped 255->0.

Function
REQ-004 SHALL pass uart_rx through a 2-flop synchronizer, both flops resetting to 1; all decisions use the synchronized value rx_s.
REQ-005 SHALL implement FSM states IDLE, START, DATA, STOP, WRITE.
REQ-006 IDLE: SHALL move to START when en=1 and rx_s=0, but only if rx_s was 1 on at least one cycle since the last return to IDLE (armed flag).
REQ-007 START: SHALL count CLKS_PER_BIT/2 cycles; then go to DATA if rx_s=0, otherwise return to IDLE (glitch reject), with no write and no flag change.
REQ-008 DATA: SHALL sample rx_s every CLKS_PER_BIT cycles, 8 samples, LSB first, into a shift register.
REQ-009 STOP: after CLKS_PER_BIT cycles SHALL sample rx_s; 1 -> WRITE; 0 -> set frame_err, discard the byte, go to IDLE (disarmed).
REQ-010 WRITE: SHALL last exactly one cycle with we=1, addr=current pointer, and din=received byte; the pointer increments on the following edge; then go to IDLE.
REQ-011 Latency: we SHALL assert on the cycle immediately after the stop-bit sample.
REQ-012 Pointer 255 + 1 SHALL wrap to 0 and set wrapped; the pointer has no saturation.
REQ-013 din SHALL hold its value until the next WRITE.
REQ-014 en=0 in any non-IDLE state SHALL abort to IDLE on the next edge with no write; pointer and flags are unchanged.
REQ-015 clr=1 SHALL set pointer=0 and clear frame_err and wrapped on the next edge; if coincident with WRITE, the write still occurs at the old address, and clr wins over both the increment and the wrap flag.
REQ-016 Bit and baud counters SHALL reset to 0 on every state change.

Reset
REQ-017 rst_=0 SHALL immediately force: state=IDLE, we=0, addr=0, din=0, busy=0, frame_err=0, wrapped=0, counters=0, shift register=0, synchronizer=1, armed=0.
REQ-018 Reset mid-frame SHALL discard the partial byte; after reset release, the next complete frame SHALL be received correctly.

Structure
REQ-019 The state enum (uart_rx_state_t) SHALL live in pkg.
REQ-020 The bit-level receiver SHALL be sub-module uart_rx (ports: clock, reset, en, rx, byte out, valid pulse, frame_err pulse).
REQ-021 uart_ram_loader SHALL own the pointer, the flags and the RAM-side outputs.
REQ-022 Outputs SHALL connect directly to the RAM's we/addr/din, with RAM ena tied to rst_.

Verification
REQ-023 Bench SHALL cover:
- Send 0xA5 at 115200 after reset -> one we pulse, addr=0, din=0xA5; then addr=1, frame_err=0.
- Send 256 bytes 0x00..0xFF -> RAM[i]=i, wrapped=1, addr=0; send one more byte -> written at addr 0.
- Frame 0x3C with stop bit driven 0 -> frame_err=1, no we, addr unchanged; the next valid frame is accepted only after the line returns high.
- 100-cycle low glitch on uart_rx -> state reaches START and returns to IDLE, no we, flags 0.
- rst_ pulsed low during DATA of byte 0x81 -> all outputs 0 within the same cycle; the following frame 0x42 is written at addr 0.
- clr asserted on the WRITE cycle at addr 7 -> RAM[7] written, addr=0 next cycle, flags 0.
